// File: rtl/lc3b_pkg.sv
// Shared LC-3b debug-path definitions: word/select widths, serializer state
// encoding and the select-stepping helper.
package lc3b_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } ser_state_e;

  // Move the bit index one position toward the far end of the word, wrapping mod 16.
  function automatic logic [SEL_W-1:0] step_select(input logic [SEL_W-1:0] sel,
                                                   input logic              down);
    step_select = down ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
  endfunction

endpackage

// File: rtl/mux16.sv
// 16:1 single-bit selector feeding the serial output; purely combinational so
// the selected bit follows the registered word and index in the same cycle.
module mux16
  import lc3b_pkg::*;
(
  input  logic              clk_50,
  input  logic [WORD_W-1:0] in,
  input  logic [SEL_W-1:0]  select,
  output logic              out
);

  assign out = in[select];

  // The clock only qualifies this sanity property; the datapath itself is unclocked.
  select_known_a : assert property (@(posedge clk_50) !$isunknown(select));

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: takes one 16-bit word over a load handshake and
// emits it one bit per accepted serial transfer through mux16.
module word_serializer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             abort,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);
  import lc3b_pkg::*;

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic [SEL_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dir_q, dir_d;
  logic             init_q, init_d;
  logic             xfer;
  logic             cnt_last;

  assign xfer     = (state_q == SEND) && ser_ready;
  assign cnt_last = (bit_cnt_q == {SEL_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    select_d  = select_q;
    bit_cnt_d = bit_cnt_q;
    dir_d     = dir_q;
    // init_q holds load_ready low until the first edge after reset release.
    init_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (init_q && load_valid && !abort) begin
          word_d    = load_data;
          dir_d     = msb_first;
          select_d  = msb_first ? {SEL_W{1'b1}} : '0;
          bit_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          select_d  = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (xfer) begin
          bit_cnt_d = bit_cnt_q + SEL_W'(1);
          select_d  = step_select(select_q, dir_q);
          if (cnt_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (abort) begin
          select_d  = '0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      select_q  <= '0;
      bit_cnt_q <= '0;
      dir_q     <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      select_q  <= select_d;
      bit_cnt_q <= bit_cnt_d;
      dir_q     <= dir_d;
      init_q    <= init_d;
    end
  end

  mux16 u_mux16 (
    .clk_50 (clk_50),
    .in     (word_q),
    .select (select_q),
    .out    (ser_bit)
  );

  assign load_ready = (state_q == IDLE) && init_q;
  assign ser_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign ser_last   = (state_q == SEND) && cnt_last;
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign done       = (state_q == DONE) && !abort;

endmodule
